// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data-length limits and frame-length
// helpers, reused by the transmit framer and the future receive block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int MIN_DBITS = 5;

    // Requested data length forced into MIN_DBITS..max_n.
    function automatic logic [3:0] clamp_nbits(input logic [3:0] n, input logic [3:0] max_n);
        if (n < 4'(MIN_DBITS)) begin
            return 4'(MIN_DBITS);
        end
        if (n > max_n) begin
            return max_n;
        end
        return n;
    endfunction

    // Start + data + optional parity + one or two stop bits.
    function automatic logic [3:0] calc_frame_len(input logic [3:0] nb, input logic par_en,
                                                  input logic two_stop);
        return 4'd2 + nb + {3'b000, par_en} + {3'b000, two_stop};
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period down-counter: load on frame accept, reload at every bit boundary,
// tick marks the last clock of the current bit.
module uart_baud_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             run,
    input  logic [DIV_W-1:0] reload_val,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run) begin
            count <= (count == '0) ? reload_val : count - 1'b1;
        end else begin
            count <= '0;
        end
    end

    assign tick = run && (count == '0);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word plus per-frame configuration and shifts out
// start, LSB-first data, optional parity and one or two stop bits on a registered txd.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int MAX_DBITS = 9,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [MAX_DBITS-1:0] data,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic [3:0]           nbits,
    input  logic                 parity_en,
    input  logic                 odd_n_even,
    input  logic                 stop2,
    output logic                 txd,
    output logic                 busy,
    output logic [3:0]           frame_len
);

    // Handshake: a word and its config transfer on any rising edge where
    // data_valid && data_ready; data_ready is high only in IDLE, and the source
    // must hold data and config stable while data_valid is high and not accepted.

    uart_state_e          state, state_next;
    logic [MAX_DBITS-1:0] shreg;
    logic [3:0]           nbits_q, bit_idx;
    logic                 par_en_q, par_bit_q, stop2_q, stop_idx;
    logic [DIV_W-1:0]     div_q;
    logic                 txd_q, txd_next;
    logic                 accept, tick;
    logic                 shift_en, bit_inc, stop_inc;
    logic [3:0]           nbits_in;
    logic                 par_in;

    assign data_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = data_valid && data_ready;
    assign txd        = txd_q;
    assign frame_len  = calc_frame_len(nbits_q, par_en_q, stop2_q);
    assign nbits_in   = clamp_nbits(nbits, 4'(MAX_DBITS));

    // Parity over the effective data bits only, computed once at accept.
    always_comb begin
        par_in = odd_n_even;
        for (int i = 0; i < MAX_DBITS; i++) begin
            if (i < int'(nbits_in)) begin
                par_in = par_in ^ data[i];
            end
        end
    end

    uart_baud_timer #(.DIV_W(DIV_W)) u_timer (
        .clk        (clk),
        .rstb       (rstb),
        .load       (accept),
        .load_val   (baud_div),
        .run        (busy),
        .reload_val (div_q),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        txd_next   = txd_q;
        shift_en   = 1'b0;
        bit_inc    = 1'b0;
        stop_inc   = 1'b0;
        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (accept) begin
                    state_next = START;
                    txd_next   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    txd_next   = shreg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == nbits_q - 4'd1) begin
                        state_next = par_en_q ? PARITY : STOP;
                        txd_next   = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_inc  = 1'b1;
                        shift_en = 1'b1;
                        txd_next = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    txd_next   = 1'b1;
                end
            end
            STOP: begin
                txd_next = 1'b1;
                if (tick) begin
                    if (stop2_q && !stop_idx) begin
                        stop_inc = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    // Reset config is 8N1 so frame_len reads 10 before the first frame.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            txd_q     <= 1'b1;
            shreg     <= '0;
            nbits_q   <= 4'd8;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
        end else begin
            txd_q <= txd_next;
            if (accept) begin
                shreg     <= data;
                nbits_q   <= nbits_in;
                par_en_q  <= parity_en;
                par_bit_q <= par_in;
                stop2_q   <= stop2;
                div_q     <= baud_div;
                bit_idx   <= '0;
                stop_idx  <= 1'b0;
            end else begin
                if (shift_en) begin
                    shreg <= shreg >> 1;
                end
                if (bit_inc) begin
                    bit_idx <= bit_idx + 4'd1;
                end
                if (stop_inc) begin
                    stop_idx <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed and randomized frames checked bit-by-bit against a frame model built
// from the line format (start, LSB-first data, parity, stop bits).
module tb_uart_tx_framer;

    logic        clk = 1'b0;
    logic        rstb;
    logic [15:0] baud_div;
    logic [8:0]  data;
    logic        data_valid;
    logic        data_ready;
    logic [3:0]  nbits;
    logic        parity_en;
    logic        odd_n_even;
    logic        stop2;
    logic        txd;
    logic        busy;
    logic [3:0]  frame_len;

    int errors = 0;
    int checks = 0;
    logic [0:0] exp_q[$];

    uart_tx_framer #(.MAX_DBITS(9), .DIV_W(16)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .baud_div   (baud_div),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .nbits      (nbits),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .stop2      (stop2),
        .txd        (txd),
        .busy       (busy),
        .frame_len  (frame_len)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line levels, one entry per bit time.
    function automatic void build_frame(input logic [8:0] d, input int nb_req, input bit pen,
                                        input bit odd, input bit s2);
        int nb;
        int ones;
        int b;
        exp_q.delete();
        nb = (nb_req < 5) ? 5 : ((nb_req > 9) ? 9 : nb_req);
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            b = (int'(d) >> i) % 2;
            ones += b;
            exp_q.push_back(b[0]);
        end
        if (pen) begin
            if (odd) exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
            else     exp_q.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
        end
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endfunction

    task automatic drive(input logic [8:0] d, input logic [3:0] nb, input bit pen,
                         input bit odd, input bit s2, input logic [15:0] div);
        @(negedge clk);
        data       = d;
        nbits      = nb;
        parity_en  = pen;
        odd_n_even = odd;
        stop2      = s2;
        baud_div   = div;
        data_valid = 1'b1;
    endtask

    task automatic scramble_inputs();
        data       = 9'($urandom_range(0, 511));
        nbits      = 4'($urandom_range(0, 15));
        parity_en  = 1'($urandom_range(0, 1));
        odd_n_even = 1'($urandom_range(0, 1));
        stop2      = 1'($urandom_range(0, 1));
        baud_div   = 16'($urandom_range(0, 7));
    endtask

    // Called just after the accepting edge; ends on the idle cycle after the frame.
    task automatic check_frame(input int div, input bit scramble, input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            for (int c = 0; c <= div; c++) begin
                @(negedge clk);
                chk($sformatf("%s txd bit%0d clk%0d", tag, i, c), 32'(txd), 32'(exp_q[i]));
                chk($sformatf("%s busy bit%0d", tag, i), 32'(busy), 32'd1);
                chk($sformatf("%s ready bit%0d", tag, i), 32'(data_ready), 32'd0);
                if (i == 0 && c == 0)
                    chk($sformatf("%s frame_len", tag), 32'(frame_len), 32'(exp_q.size()));
                if (scramble) scramble_inputs();
            end
        end
        @(negedge clk);
        chk($sformatf("%s idle txd", tag), 32'(txd), 32'd1);
        chk($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
        chk($sformatf("%s idle ready", tag), 32'(data_ready), 32'd1);
    endtask

    task automatic accept_and_drop();
        @(posedge clk);
        #1 data_valid = 1'b0;
    endtask

    initial begin
        logic [8:0]  rd;
        logic [3:0]  rn;
        bit          rp, ro, rs;
        logic [15:0] rdiv;

        // Reset state
        rstb = 1'b0;
        data_valid = 1'b0;
        scramble_inputs();
        repeat (3) @(negedge clk);
        chk("reset txd", 32'(txd), 32'd1);
        chk("reset ready", 32'(data_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset frame_len", 32'(frame_len), 32'd10);
        rstb = 1'b1;
        repeat (2) @(negedge clk);

        // 8 data bits, even parity, one stop, 4 clocks per bit
        drive(9'h04A, 4'd8, 1'b1, 1'b0, 1'b0, 16'd3);
        accept_and_drop();
        build_frame(9'h04A, 8, 1'b1, 1'b0, 1'b0);
        check_frame(3, 1'b1, "t2");

        // 7 data bits, odd parity, two stops
        drive(9'h04A, 4'd7, 1'b1, 1'b1, 1'b1, 16'd2);
        accept_and_drop();
        build_frame(9'h04A, 7, 1'b1, 1'b1, 1'b1);
        check_frame(2, 1'b1, "t3");

        // nbits below minimum clamps to 5, one clock per bit
        drive(9'h01F, 4'd3, 1'b0, 1'b0, 1'b0, 16'd0);
        accept_and_drop();
        build_frame(9'h01F, 3, 1'b0, 1'b0, 1'b0);
        check_frame(0, 1'b1, "t4");

        // Randomized frames, including nbits above the maximum
        for (int k = 0; k < 12; k++) begin
            rd   = 9'($urandom_range(0, 511));
            rn   = 4'($urandom_range(0, 15));
            rp   = 1'($urandom_range(0, 1));
            ro   = 1'($urandom_range(0, 1));
            rs   = 1'($urandom_range(0, 1));
            rdiv = 16'($urandom_range(0, 3));
            drive(rd, rn, rp, ro, rs, rdiv);
            accept_and_drop();
            build_frame(rd, int'(rn), rp, ro, rs);
            check_frame(int'(rdiv), 1'b1, $sformatf("rand%0d", k));
        end

        // Reset during data bit 3 of an all-zero word
        drive(9'h000, 4'd8, 1'b0, 1'b0, 1'b0, 16'd3);
        accept_and_drop();
        repeat (17) @(negedge clk);
        chk("t5 pre-reset txd", 32'(txd), 32'd0);
        chk("t5 pre-reset busy", 32'(busy), 32'd1);
        #2 rstb = 1'b0;
        #1;
        chk("t5 reset txd", 32'(txd), 32'd1);
        chk("t5 reset busy", 32'(busy), 32'd0);
        chk("t5 reset ready", 32'(data_ready), 32'd1);
        chk("t5 reset frame_len", 32'(frame_len), 32'd10);
        @(negedge clk);
        rstb = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            chk($sformatf("t5 post txd clk%0d", c), 32'(txd), 32'd1);
            chk($sformatf("t5 post ready clk%0d", c), 32'(data_ready), 32'd1);
        end

        // Back-to-back with data_valid held; inputs change right after the first accept
        drive(9'h055, 4'd8, 1'b0, 1'b0, 1'b0, 16'd1);
        @(posedge clk);
        #1;
        data       = 9'h0AA;
        parity_en  = 1'b1;
        odd_n_even = 1'b0;
        stop2      = 1'b1;
        baud_div   = 16'd2;
        build_frame(9'h055, 8, 1'b0, 1'b0, 1'b0);
        check_frame(1, 1'b0, "t6a");
        accept_and_drop();
        build_frame(9'h0AA, 8, 1'b1, 1'b0, 1'b1);
        check_frame(2, 1'b0, "t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
